uart_rx: RTL and testbench

//   Receives an 8N1 serial frame on rxd using oversampling ticks from baud_generate.

---
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop sampling, one byte per frame into the RX FIFO.
// Latency: rx_ready/rx_error assert one PCLK after the stop-bit sampling edge, one cycle wide.
// Backpressure: none toward the line; full_rx at stop-bit sample turns the frame into an overrun error.
//
// Ports:
//   PCLK, PRESET         clock and synchronous active-high reset
//   baud_tick            1-cycle pulse at OVERSAMPLE x baud rate
//   rx_en                receiver enable; dropping it aborts any frame in progress
//   rxd                  asynchronous serial input, idle high
//   full_rx              RX FIFO full
//   rx_dout              last good byte, zero-extended; held between frames
//   rx_ready             1-cycle write strobe for a good frame
//   rx_busy              high while state is not IDLE
//   rx_error             1-cycle pulse on framing error or overrun
module uart_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  baud_tick,
    input  logic                  rx_en,
    input  logic                  rxd,
    input  logic                  full_rx,
    output logic [DATA_WIDTH-1:0] rx_dout,
    output logic                  rx_ready,
    output logic                  rx_busy,
    output logic                  rx_error
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_rxd_prev;
    logic [TW-1:0]         r_tick_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_error;

    state_t                w_state_nxt;
    logic [TW-1:0]         w_tick_nxt;
    logic [BW-1:0]         w_bit_nxt;
    logic [DATA_BITS-1:0]  w_shift_nxt;
    logic [DATA_WIDTH-1:0] w_dout_nxt;
    logic                  w_ready_nxt;
    logic                  w_error_nxt;
    logic                  w_fall;

    // Edge-qualified arming: a line held low (break) never produces a second edge.
    assign w_fall = r_rxd_prev & ~r_sync2;

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_dout_nxt  = r_dout;
        w_ready_nxt = 1'b0;
        w_error_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_en && w_fall) begin
                    w_state_nxt = S_START;
                    w_tick_nxt  = '0;
                end
            end
            S_START: begin
                if (!rx_en) begin
                    w_state_nxt = S_IDLE;
                end else if (baud_tick) begin
                    if (r_tick_cnt == HALF_M1) begin
                        // Mid-start-bit check; a high line here was only a glitch.
                        if (!r_sync2) begin
                            w_state_nxt = S_DATA;
                            w_tick_nxt  = '0;
                            w_bit_nxt   = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (!rx_en) begin
                    w_state_nxt = S_IDLE;
                end else if (baud_tick) begin
                    if (r_tick_cnt == FULL_M1) begin
                        // LSB arrives first, so shift in from the top.
                        w_shift_nxt = {r_sync2, r_shift[DATA_BITS-1:1]};
                        w_tick_nxt  = '0;
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (!rx_en) begin
                    w_state_nxt = S_IDLE;
                end else if (baud_tick) begin
                    if (r_tick_cnt == FULL_M1) begin
                        w_state_nxt = S_IDLE;
                        w_tick_nxt  = '0;
                        if (r_sync2 && !full_rx) begin
                            w_dout_nxt  = DATA_WIDTH'(r_shift);
                            w_ready_nxt = 1'b1;
                        end else begin
                            w_error_nxt = 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state    <= S_IDLE;
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxd_prev <= 1'b1;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_dout     <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_sync1    <= rxd;
            r_sync2    <= r_sync1;
            r_rxd_prev <= r_sync2;
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_dout     <= w_dout_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_error    <= w_error_nxt;
        end
    end

    assign rx_dout  = r_dout;
    assign rx_ready = r_ready;
    assign rx_busy  = r_busy;
    assign rx_error = r_error;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clocks

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        baud_tick;
    logic        rx_en;
    logic        rxd;
    logic        full_rx;
    logic [15:0] rx_dout;
    logic        rx_ready;
    logic        rx_busy;
    logic        rx_error;

    uart_rx #(.DATA_WIDTH(16), .DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .baud_tick (baud_tick),
        .rx_en     (rx_en),
        .rxd       (rxd),
        .full_rx   (full_rx),
        .rx_dout   (rx_dout),
        .rx_ready  (rx_ready),
        .rx_busy   (rx_busy),
        .rx_error  (rx_error)
    );

    always #5 PCLK = ~PCLK;

    logic [1:0] div = 2'd0;
    always @(posedge PCLK) div <= div + 2'd1;
    assign baud_tick = (div == 2'd3);

    typedef struct {
        logic        is_err;
        logic [15:0] dat;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         mon_ev;
    logic [15:0] exp_dout = 16'h0000;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every pulse must match the next expected frame outcome, in order.
    always @(negedge PCLK) begin
        if (!PRESET && (rx_ready || rx_error)) begin
            check("ready_error_exclusive", {31'd0, rx_ready & rx_error}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse ready=%0b error=%0b required=no_pulse", rx_ready, rx_error);
            end else begin
                mon_ev = exp_q.pop_front();
                check("pulse_is_error", {31'd0, rx_error}, {31'd0, mon_ev.is_err});
                if (!mon_ev.is_err) exp_dout = mon_ev.dat;
                check("rx_dout_at_pulse", {16'd0, rx_dout}, {16'd0, exp_dout});
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        wait_clks(n);
    endtask

    // Reference model: a frame yields a good byte only with a high stop bit and room in the FIFO.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic full);
        ev_t ev;
        ev.is_err = !(stop && !full);
        ev.dat    = {8'h00, d};
        exp_q.push_back(ev);
        full_rx = full;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        full_rx = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge PCLK);
            t++;
        end
        check({name, "_pending"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       stop;
        logic       full;

        PRESET  = 1'b1;
        rx_en   = 1'b1;
        rxd     = 1'b1;
        full_rx = 1'b0;
        wait_clks(3);
        check("reset_dout",  {16'd0, rx_dout}, 32'd0);
        check("reset_ready", {31'd0, rx_ready}, 32'd0);
        check("reset_busy",  {31'd0, rx_busy}, 32'd0);
        check("reset_error", {31'd0, rx_error}, 32'd0);
        PRESET = 1'b0;
        idle(10);

        // Good frame
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);
        drain("a5");
        check("a5_dout", {16'd0, rx_dout}, 32'h00A5);

        // Short low glitch rejected at mid-start-bit
        rxd = 1'b0;
        wait_clks(8);
        check("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
        wait_clks(8);
        rxd = 1'b1;
        wait_clks(40);
        check("glitch_busy_lo", {31'd0, rx_busy}, 32'd0);
        idle(40);
        drain("glitch");

        // Framing error followed by a break
        send_frame(8'h3C, 1'b0, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        check("break_busy", {31'd0, rx_busy}, 32'd0);
        idle(64);
        drain("framing");
        check("framing_dout", {16'd0, rx_dout}, 32'h00A5);

        // Overrun
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(64);
        drain("overrun");
        check("overrun_dout", {16'd0, rx_dout}, 32'h00A5);

        // Abort by rx_en during bit 4, then a clean retry
        d = 8'h77;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rxd = d[4];
        wait_clks(10);
        check("abort_busy_pre", {31'd0, rx_busy}, 32'd1);
        rx_en = 1'b0;
        wait_clks(1);
        check("abort_busy_next", {31'd0, rx_busy}, 32'd0);
        wait_clks(BIT_CLKS - 11);
        for (int i = 5; i < 8; i++) drive_bit(d[i]);
        drive_bit(1'b1);
        idle(64);
        check("abort_busy_after", {31'd0, rx_busy}, 32'd0);
        rx_en = 1'b1;
        idle(16);
        drain("abort");
        check("abort_dout", {16'd0, rx_dout}, 32'h00A5);
        send_frame(8'h77, 1'b1, 1'b0);
        idle(20);
        drain("retry");
        check("retry_dout", {16'd0, rx_dout}, 32'h0077);

        // Back-to-back frames, then reset mid-frame
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drain("b2b");
        check("b2b_dout", {16'd0, rx_dout}, 32'h00FF);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rxd = 1'b0;
        wait_clks(20);
        check("midframe_busy", {31'd0, rx_busy}, 32'd1);
        PRESET = 1'b1;
        rxd    = 1'b1;
        wait_clks(1);
        exp_dout = 16'h0000;
        check("midreset_dout",  {16'd0, rx_dout}, 32'd0);
        check("midreset_ready", {31'd0, rx_ready}, 32'd0);
        check("midreset_busy",  {31'd0, rx_busy}, 32'd0);
        check("midreset_error", {31'd0, rx_error}, 32'd0);
        wait_clks(2);
        PRESET = 1'b0;
        idle(20);

        // Randomized frames
        for (int n = 0; n < 12; n++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 7) != 0);
            full = ($urandom_range(0, 5) == 0);
            send_frame(d, stop, full);
            if (stop) idle($urandom_range(0, 40));
            else      idle($urandom_range(16, 40));
        end
        idle(64);
        drain("random");
        check("random_dout", {16'd0, rx_dout}, {16'd0, exp_dout});
        check("final_busy", {31'd0, rx_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
